// File: rtl/piso_shift_register_tx_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmit register.
package piso_shift_register_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit-counter width for an n-bit word; stays at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-N up-counter with synchronous clear and enable; flags the terminal count.
module piso_bit_counter
  import piso_shift_register_tx_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = cnt_width(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over enable so a reload always restarts at bit zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/piso_shift_register_tx.sv
// Parallel-in, serial-out transmitter: load/ready handshake in, one bit per clock out.
module piso_shift_register_tx
  import piso_shift_register_tx_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         load,
  output logic         ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         last
);

  localparam int unsigned CNT_W = cnt_width(N);

  state_t       state_q, state_d;
  logic [N-1:0] shreg_q, shreg_d;
  logic [N-1:0] shreg_shifted;
  logic         cnt_clr, cnt_en, cnt_tc;
  logic         accept;

  piso_bit_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc_c  (cnt_tc)
  );

  // Outputs are decoded purely from registered state; din/load never reach them.
  assign sout_valid = (state_q == ST_SHIFT);
  assign last       = sout_valid && cnt_tc;
  assign ready      = (state_q == ST_IDLE) || last;
  assign sout       = sout_valid && (LSB_FIRST ? shreg_q[0] : shreg_q[N-1]);
  assign accept     = load && ready;

  assign shreg_shifted = LSB_FIRST ? {1'b0, shreg_q[N-1:1]} : {shreg_q[N-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state: an accept on the last bit reloads in place, giving gapless words.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          shreg_d = din;
          cnt_clr = 1'b1;
        end else if (last) begin
          shreg_d = '0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          shreg_d = shreg_shifted;
          cnt_en  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shift_register_tx.sv
// Scoreboard bench: MSB-first and LSB-first instances driven from the same source.
module tb_piso_shift_register_tx;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [N-1:0] din;

  logic ready_m, sout_m, valid_m, last_m;
  logic ready_l, sout_l, valid_l, last_l;

  exp_t q_m[$];
  exp_t q_l[$];
  int   rem    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piso_shift_register_tx #(.N(N), .LSB_FIRST(1'b0)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .load       (load),
    .ready      (ready_m),
    .sout       (sout_m),
    .sout_valid (valid_m),
    .last       (last_m)
  );

  piso_shift_register_tx #(.N(N), .LSB_FIRST(1'b1)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .load       (load),
    .ready      (ready_l),
    .sout       (sout_l),
    .sout_valid (valid_l),
    .last       (last_l)
  );

  // Reference model: rem = bits still to be shown, counting the current one.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      rem = 0;
      q_m.delete();
      q_l.delete();
    end else if (load && rem <= 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        e.b = din[i];
        e.l = (i == 0);
        q_m.push_back(e);
      end
      for (int i = 0; i < N; i++) begin
        e.b = din[i];
        e.l = (i == N - 1);
        q_l.push_back(e);
      end
      rem = N;
    end else if (rem > 0) begin
      rem = rem - 1;
    end
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    logic exp_r;
    if (rst_n) begin
      exp_v = (rem > 0);
      exp_r = (rem <= 1);
      checks += 2;
      if (ready_m !== exp_r) begin
        errors++;
        $display("FAIL ready_msb got %b want %b at %0t", ready_m, exp_r, $time);
      end
      if (ready_l !== exp_r) begin
        errors++;
        $display("FAIL ready_lsb got %b want %b at %0t", ready_l, exp_r, $time);
      end
      checks += 2;
      if (valid_m !== exp_v) begin
        errors++;
        $display("FAIL valid_msb got %b want %b at %0t", valid_m, exp_v, $time);
      end
      if (valid_l !== exp_v) begin
        errors++;
        $display("FAIL valid_lsb got %b want %b at %0t", valid_l, exp_v, $time);
      end
      if (exp_v) begin
        checks += 2;
        if (q_m.size() == 0) begin
          errors++;
          $display("FAIL sb_msb_underflow got empty want bit at %0t", $time);
        end else begin
          e = q_m.pop_front();
          if (sout_m !== e.b || last_m !== e.l) begin
            errors++;
            $display("FAIL bit_msb got sout=%b last=%b want sout=%b last=%b at %0t",
                     sout_m, last_m, e.b, e.l, $time);
          end
        end
        if (q_l.size() == 0) begin
          errors++;
          $display("FAIL sb_lsb_underflow got empty want bit at %0t", $time);
        end else begin
          e = q_l.pop_front();
          if (sout_l !== e.b || last_l !== e.l) begin
            errors++;
            $display("FAIL bit_lsb got sout=%b last=%b want sout=%b last=%b at %0t",
                     sout_l, last_l, e.b, e.l, $time);
          end
        end
      end else begin
        checks++;
        if ({sout_m, last_m, sout_l, last_l} !== 4'b0000) begin
          errors++;
          $display("FAIL idle_outputs got %b want 0000 at %0t",
                   {sout_m, last_m, sout_l, last_l}, $time);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    din   = '0;
    #1;
    checks++;
    if ({valid_m, sout_m, last_m, ready_m, valid_l, sout_l, last_l, ready_l} !== 8'b0001_0001) begin
      errors++;
      $display("FAIL reset_state got %b want 00010001",
               {valid_m, sout_m, last_m, ready_m, valid_l, sout_l, last_l, ready_l});
    end
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic test_word_done(input string name);
    checks++;
    if (q_m.size() != 0 || q_l.size() != 0 || valid_m !== 1'b0 || ready_m !== 1'b1) begin
      errors++;
      $display("FAIL %s_end got q=%0d/%0d valid=%b ready=%b want 0/0 0 1",
               name, q_m.size(), q_l.size(), valid_m, ready_m);
    end
  endtask

  task automatic test_single_word();
    @(negedge clk);
    load = 1'b1;
    din  = 4'b1011;
    @(negedge clk);
    load = 1'b0;
    wait_cycles(5);
    test_word_done("single");
  endtask

  task automatic test_back_to_back();
    int valid_cnt = 0;
    @(negedge clk);
    load = 1'b1;
    din  = 4'b1011;
    @(negedge clk);
    load = 1'b0;
    if (valid_m) valid_cnt++;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (valid_m) valid_cnt++;
      load = (c == 4);
      din  = (c == 4) ? 4'b0110 : 4'b0000;
    end
    checks++;
    if (valid_cnt != 8) begin
      errors++;
      $display("FAIL b2b_contiguous got %0d valid cycles want 8", valid_cnt);
    end
    wait_cycles(2);
    test_word_done("b2b");
  endtask

  task automatic test_busy_reject();
    @(negedge clk);
    load = 1'b1;
    din  = 4'b1011;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    load = 1'b1;
    din  = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    wait_cycles(3);
    test_word_done("busy");
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    load = 1'b1;
    din  = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_m, sout_m, last_m, valid_l, sout_l, last_l} !== 6'b0 ||
        ready_m !== 1'b1 || ready_l !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v/s/l=%b ready=%b%b want 000000 ready=11",
               {valid_m, sout_m, last_m, valid_l, sout_l, last_l}, ready_m, ready_l);
    end
    wait_cycles(2);
    #1;
    rst_n = 1'b1;
    load  = 1'b1;
    din   = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    wait_cycles(5);
    test_word_done("post_reset");
  endtask

  task automatic test_din_stability();
    @(negedge clk);
    load = 1'b1;
    din  = 4'b1001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      load = 1'b0;
      din  = 4'($urandom);
    end
    wait_cycles(2);
    test_word_done("din_stable");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_word();
    test_din_stability();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_register_tx.md
Name: piso_shift_register_tx

Overview:
- Parallel-in, serial-out transmit register. It is the unloading end of our parallel-load register path.
- Accepts an N-bit word through a load/ready handshake, then shifts it out one bit per clock with a valid strobe and a last-bit marker.
- Sits between a parallel data source (register or FIFO output) and a serial link or deserializer.
- Supports gapless back-to-back words.

Parameters:
- N, 4, word width in bits; legal range N >= 2.
- LSB_FIRST, 0, shift order: 0 = MSB first, 1 = LSB first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  N  parallel word to transmit; sampled only on an accepted load.
- load  input  1  load request from the source.
- ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- last  output  1  current sout is the final bit of the word.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
  - rst_n low immediately forces state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, last=0.
  - ready=1 while in IDLE, including during reset.
- States: IDLE, SHIFT. All outputs are registered or decoded from registered state. No combinational path from din or load to any output.
- Accept rule: a word is accepted at a rising edge where load=1 and ready=1. A load with ready=0 is ignored and has no side effects.
- ready = (state==IDLE) or (state==SHIFT and last==1).
- IDLE:
  - sout=0, sout_valid=0, last=0.
  - On accept: capture din into the shift register, counter=0, go to SHIFT.
- SHIFT:
  - sout_valid=1.
  - sout = shreg[N-1] when LSB_FIRST=0; shreg[0] when LSB_FIRST=1.
  - Each edge shifts the register one position toward the output end, zero-filled, and increments the counter.
  - last = (counter == N-1).
- Latency: the first bit appears on sout in the cycle after the accept edge. The word occupies exactly N consecutive valid cycles.
- End of word, on the edge that ends the last=1 cycle:
  - With an accept on that edge: reload din, counter=0, stay in SHIFT. The next word's first bit follows with no gap.
  - Without an accept: go to IDLE, sout_valid drops to 0.
- din changes after the accept edge have no effect on the word in flight.
- Counter width is $clog2(N). It never exceeds N-1, and wraps to 0 only through a reload.
- Reset asserted mid-word: the word is discarded and there is no partial output afterward. After release, the block is in IDLE and can accept on the first edge.

Decomposition:
- Shared header/package: state encoding localparams (ST_IDLE=1'b0, ST_SHIFT=1'b1) and the counter-width function/localparam CNT_W = $clog2(N).
- One natural sub-module: piso_bit_counter, a modulo-N up-counter with clear and enable that outputs the terminal-count flag used as last.
- The shift register and FSM stay in the top module.

Test Plan:
- N=4, LSB_FIRST=0:
  - Stimulus: load 4'b1011 at edge 0.
  - Response: cycles 1-4 sout=1,0,1,1 with sout_valid=1; last=1 only in cycle 4; ready=0 in cycles 1-3 and 1 in cycle 4; sout_valid=0 in cycle 5.
- Back-to-back:
  - Stimulus: load 4'b1011, then hold load=1 with din=4'b0110 during cycle 4.
  - Response: 8 contiguous valid bits 1,0,1,1,0,1,1,0; last in cycles 4 and 8; no idle gap.
- Busy rejection:
  - Stimulus: load 4'b1011, then load=1 with din=4'b1100 in cycles 2-3 (ready=0).
  - Response: output stays 1,0,1,1, then IDLE; 4'b1100 is never transmitted.
- LSB_FIRST=1:
  - Stimulus: load 4'b1011.
  - Response: sout=1,1,0,1 in cycles 1-4.
- Reset mid-word:
  - Stimulus: load 4'b1111, pull rst_n low mid-cycle 2 (asynchronous, between edges).
  - Response: sout, sout_valid and last go to 0 without waiting for a clock edge.
  - Follow-up: release rst_n, then load 4'b0001; response is 0,0,0,1 cleanly, with last in the 4th bit.
- din stability:
  - Stimulus: load 4'b1001, then toggle din every cycle during the shift.
  - Response: output is exactly 1,0,0,1.
